// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state codes, coin codes and
// the coin-to-credit conversion.
package vend_pkg;

    localparam logic [3:0] IDLE     = 4'b0000;
    localparam logic [3:0] ACCUM    = 4'b0001;
    localparam logic [3:0] DISPENSE = 4'b0010;
    localparam logic [3:0] CHANGE   = 4'b0100;
    localparam logic [3:0] REFUND   = 4'b1000;
    localparam logic [3:0] FAULT    = 4'b1111;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10,
        COIN_25   = 2'b11
    } coin_t;

    function automatic logic [4:0] coin_value(input coin_t c);
        case (c)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            COIN_25: return 5'd25;
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_seq_if.sv
// Coin, button, handshake and status signals between the vending sequencer
// (slave side) and the machine front end / dispenser / payout (master side).
interface vend_seq_if #(
    parameter int CW = 7
);
    logic [1:0]    CN;
    logic          ST;
    logic          CNCL;
    logic          DISP_ACK;
    logic          CHG_ACK;
    logic          DISP_REQ;
    logic          CHG_REQ;
    logic [CW-1:0] CHG_AMT;
    logic [CW-1:0] CREDIT;
    logic [3:0]    CS;
    logic          COIN_REJ;
    logic          LOW_CR;
    logic          FAULT;

    modport slave (
        input  CN, ST, CNCL, DISP_ACK, CHG_ACK,
        output DISP_REQ, CHG_REQ, CHG_AMT, CREDIT, CS, COIN_REJ, LOW_CR, FAULT
    );

    modport master (
        output CN, ST, CNCL, DISP_ACK, CHG_ACK,
        input  DISP_REQ, CHG_REQ, CHG_AMT, CREDIT, CS, COIN_REJ, LOW_CR, FAULT
    );
endinterface

// File: rtl/vend_timer.sv
// Saturating cycle counter with a terminal flag; serves as both the idle
// timeout and the dispenser watchdog since the two are never live together.
module vend_timer #(
    parameter int TIMEOUT = 1000,
    parameter int TW      = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt;

    // Stops at LIMIT so a late exit can never wrap back into a fresh count.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == LIMIT);

endmodule

// File: rtl/vend_seq.sv
// Vending machine sequencer: coin credit accumulation, vend decision,
// dispense and payout handshakes, cancel/timeout refund and watchdog fault.
module vend_seq
    import vend_pkg::*;
#(
    parameter int PRICE      = 65,
    parameter int CREDIT_MAX = 95,
    parameter int CW         = 7,
    parameter int TIMEOUT    = 1000,
    parameter int TW         = 16
) (
    input  logic       CLK,
    input  logic       RST,
    vend_seq_if.slave  bus
);
    localparam logic [CW-1:0] PRICE_W = CW'(PRICE);
    localparam logic [CW:0]   MAX_EXT = (CW+1)'(CREDIT_MAX);

    logic [3:0]    state, state_nxt;
    logic [CW-1:0] credit, credit_nxt;
    logic          coin_rej, coin_rej_nxt;
    logic          low_cr, low_cr_nxt;
    logic          coin_in, coin_acc, coin_fits;
    logic [CW-1:0] cval;
    logic [CW:0]   sum;
    logic          tmr_clr, tmr_en, tmr_done;
    logic          chg_req;

    vend_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .done (tmr_done)
    );

    always_comb begin
        cval         = CW'(coin_value(coin_t'(bus.CN)));
        sum          = {1'b0, credit} + {1'b0, cval};
        coin_in      = (bus.CN != COIN_NONE);
        coin_fits    = (sum <= MAX_EXT);
        state_nxt    = state;
        credit_nxt   = credit;
        coin_rej_nxt = 1'b0;
        low_cr_nxt   = 1'b0;
        coin_acc     = 1'b0;

        case (state)
            IDLE: begin
                if (coin_in) begin
                    credit_nxt = cval;
                    state_nxt  = ACCUM;
                end
            end

            ACCUM: begin
                if (bus.CNCL) begin
                    state_nxt = REFUND;
                end else if (coin_in && coin_fits) begin
                    credit_nxt = sum[CW-1:0];
                    coin_acc   = 1'b1;
                end else if (coin_in) begin
                    // Rejected coin does not restart the idle timer.
                    coin_rej_nxt = 1'b1;
                    if (tmr_done) state_nxt = REFUND;
                end else if (bus.ST && (credit >= PRICE_W)) begin
                    credit_nxt = credit - PRICE_W;
                    state_nxt  = DISPENSE;
                end else begin
                    low_cr_nxt = bus.ST;
                    if (tmr_done) state_nxt = REFUND;
                end
            end

            DISPENSE: begin
                coin_rej_nxt = coin_in;
                if (bus.DISP_ACK) begin
                    state_nxt = (credit != '0) ? CHANGE : IDLE;
                end else if (tmr_done) begin
                    state_nxt = FAULT;
                end
            end

            CHANGE, REFUND: begin
                coin_rej_nxt = coin_in;
                if (bus.CHG_ACK) begin
                    credit_nxt = '0;
                    state_nxt  = IDLE;
                end
            end

            FAULT: begin
                coin_rej_nxt = coin_in;
            end

            default: begin
                state_nxt  = IDLE;
                credit_nxt = '0;
            end
        endcase

        // Timer restarts on every state change and accepted coin.
        tmr_en  = (state == ACCUM) || (state == DISPENSE);
        tmr_clr = (state_nxt != state) || coin_acc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            credit   <= '0;
            coin_rej <= 1'b0;
            low_cr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            credit   <= credit_nxt;
            coin_rej <= coin_rej_nxt;
            low_cr   <= low_cr_nxt;
        end
    end

    assign chg_req      = (state == CHANGE) || (state == REFUND);
    assign bus.DISP_REQ = (state == DISPENSE);
    assign bus.CHG_REQ  = chg_req;
    assign bus.CHG_AMT  = chg_req ? credit : '0;
    assign bus.CREDIT   = credit;
    assign bus.CS       = state;
    assign bus.COIN_REJ = coin_rej;
    assign bus.LOW_CR   = low_cr;
    assign bus.FAULT    = (state == FAULT);

endmodule
